// File: rtl/sdram_uart_pkg.sv
// Shared definitions for the UART <-> SDRAM burst path: FSM encoding, grant type
// and default ring geometry.
package sdram_uart_pkg;

    localparam int unsigned DEF_ADDR_W   = 24;
    localparam logic [23:0] DEF_ADDR_MIN = 24'd0;
    localparam logic [23:0] DEF_ADDR_MAX = 24'd1023;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst start-address pointer for the SDRAM ring: advances by burst_len when a
// burst completes and wraps to ADDR_MIN when the next burst would overrun ADDR_MAX.
module burst_addr_gen
    import sdram_uart_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] ADDR_MIN = ADDR_W'(DEF_ADDR_MIN),
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEF_ADDR_MAX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic [9:0]        burst_len,
    output logic [ADDR_W-1:0] addr
);

    typedef logic [ADDR_W+1:0] wide_t;

    wide_t next_addr;
    wide_t next_end;
    logic  wrap;

    // Two guard bits keep the end-of-burst sum from overflowing near the top of the address space.
    always_comb begin
        next_addr = wide_t'(addr) + wide_t'(burst_len);
        next_end  = next_addr + wide_t'(burst_len) - wide_t'(1);
        wrap      = next_end > wide_t'(ADDR_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= ADDR_MIN;
        end else if (advance) begin
            addr <= wrap ? ADDR_MIN : ADDR_W'(next_addr);
        end
    end

endmodule

// File: rtl/sdram_burst_sched.sv
// Burst scheduler between the UART FIFOs and the SDRAM controller: round-robin
// write/read arbitration, req/ack handshake, ring pointers and stored-word count.
module sdram_burst_sched
    import sdram_uart_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] ADDR_MIN = ADDR_W'(DEF_ADDR_MIN),
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEF_ADDR_MAX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_end,
    input  logic [9:0]        burst_len,
    input  logic [9:0]        wr_fifo_num,
    input  logic [9:0]        rd_fifo_num,
    input  logic              rd_valid,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic              sdram_wr_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic              wr_burst_done,
    output logic              rd_burst_done,
    output logic [ADDR_W:0]   stored_cnt
);

    typedef logic [ADDR_W+1:0] occ_t;
    typedef logic [ADDR_W:0]   cnt_t;

    localparam occ_t CAP = occ_t'(ADDR_MAX) - occ_t'(ADDR_MIN) + occ_t'(1);

    logic [1:0] state;
    grant_t     last_grant;
    logic       wr_ack_d;
    logic       rd_ack_d;
    logic       wr_fall;
    logic       rd_fall;
    logic       wr_elig;
    logic       rd_elig;

    always_comb begin
        wr_elig = (burst_len != '0) && (wr_fifo_num >= burst_len) &&
                  (occ_t'(stored_cnt) + occ_t'(burst_len) <= CAP);
        rd_elig = (burst_len != '0) && rd_valid &&
                  (occ_t'(stored_cnt) >= occ_t'(burst_len)) && (rd_fifo_num == '0);
        wr_fall = (state == ST_WRITE) && wr_ack_d && !sdram_wr_ack;
        rd_fall = (state == ST_READ)  && rd_ack_d && !sdram_rd_ack;
    end

    // Ack history is only kept inside the matching burst state, so a stray ack
    // seen before the request cannot produce a falling edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_d <= 1'b0;
            rd_ack_d <= 1'b0;
        end else begin
            wr_ack_d <= (state == ST_WRITE) && sdram_wr_ack;
            rd_ack_d <= (state == ST_READ)  && sdram_rd_ack;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            last_grant    <= GRANT_READ;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            wr_burst_done <= 1'b0;
            rd_burst_done <= 1'b0;
            stored_cnt    <= '0;
        end else begin
            wr_burst_done <= 1'b0;
            rd_burst_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (init_end) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!init_end) begin
                        state <= ST_INIT;
                    end else if (wr_elig && (!rd_elig || last_grant == GRANT_READ)) begin
                        state        <= ST_WRITE;
                        sdram_wr_req <= 1'b1;
                        last_grant   <= GRANT_WRITE;
                    end else if (rd_elig) begin
                        state        <= ST_READ;
                        sdram_rd_req <= 1'b1;
                        last_grant   <= GRANT_READ;
                    end
                end
                ST_WRITE: begin
                    if (wr_fall) begin
                        state         <= ST_IDLE;
                        sdram_wr_req  <= 1'b0;
                        wr_burst_done <= 1'b1;
                        stored_cnt    <= stored_cnt + cnt_t'(burst_len);
                    end
                end
                ST_READ: begin
                    if (rd_fall) begin
                        state         <= ST_IDLE;
                        sdram_rd_req  <= 1'b0;
                        rd_burst_done <= 1'b1;
                        stored_cnt    <= stored_cnt - cnt_t'(burst_len);
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    burst_addr_gen #(
        .ADDR_W   (ADDR_W),
        .ADDR_MIN (ADDR_MIN),
        .ADDR_MAX (ADDR_MAX)
    ) u_wr_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (wr_fall),
        .burst_len (burst_len),
        .addr      (sdram_wr_addr)
    );

    burst_addr_gen #(
        .ADDR_W   (ADDR_W),
        .ADDR_MIN (ADDR_MIN),
        .ADDR_MAX (ADDR_MAX)
    ) u_rd_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (rd_fall),
        .burst_len (burst_len),
        .addr      (sdram_rd_addr)
    );

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Self-checking bench for sdram_burst_sched on a 30-word ring; a word-count and
// pointer model of the scheduler predicts every grant, address and occupancy.
module tb_sdram_burst_sched;

    localparam int unsigned AW    = 24;
    localparam int unsigned A_MIN = 0;
    localparam int unsigned A_MAX = 29;
    localparam int unsigned CAP   = A_MAX - A_MIN + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_end;
    logic [9:0]    burst_len;
    logic [9:0]    wr_fifo_num;
    logic [9:0]    rd_fifo_num;
    logic          rd_valid;
    logic          sdram_wr_ack;
    logic          sdram_rd_ack;
    logic          sdram_wr_req;
    logic [AW-1:0] sdram_wr_addr;
    logic          sdram_rd_req;
    logic [AW-1:0] sdram_rd_addr;
    logic          wr_burst_done;
    logic          rd_burst_done;
    logic [AW:0]   stored_cnt;

    int checks = 0;
    int errors = 0;

    int unsigned m_stored;
    int unsigned m_wr_addr;
    int unsigned m_rd_addr;
    bit          m_last_read;

    always #5 clk = ~clk;

    sdram_burst_sched #(
        .ADDR_W   (AW),
        .ADDR_MIN (24'd0),
        .ADDR_MAX (24'd29)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_end      (init_end),
        .burst_len     (burst_len),
        .wr_fifo_num   (wr_fifo_num),
        .rd_fifo_num   (rd_fifo_num),
        .rd_valid      (rd_valid),
        .sdram_wr_ack  (sdram_wr_ack),
        .sdram_rd_ack  (sdram_rd_ack),
        .sdram_wr_req  (sdram_wr_req),
        .sdram_wr_addr (sdram_wr_addr),
        .sdram_rd_req  (sdram_rd_req),
        .sdram_rd_addr (sdram_rd_addr),
        .wr_burst_done (wr_burst_done),
        .rd_burst_done (rd_burst_done),
        .stored_cnt    (stored_cnt)
    );

    function automatic int unsigned next_start(int unsigned a, int unsigned len);
        int unsigned n;
        n = a + len;
        if (n + len - 1 > A_MAX) n = A_MIN;
        return n;
    endfunction

    // 0 = nothing granted, 1 = write burst, 2 = read burst
    function automatic int exp_grant();
        int unsigned bl;
        bit we;
        bit re;
        bl = 32'(burst_len);
        we = (bl != 0) && (32'(wr_fifo_num) >= bl) && (m_stored + bl <= CAP);
        re = (bl != 0) && (rd_valid === 1'b1) && (m_stored >= bl) && (rd_fifo_num == 10'd0);
        if (we && re) return m_last_read ? 1 : 2;
        if (we) return 1;
        if (re) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_stored    = 0;
        m_wr_addr   = A_MIN;
        m_rd_addr   = A_MIN;
        m_last_read = 1'b1;
    endtask

    task automatic do_reset();
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called at a negedge with the DUT idle; plays the controller for whatever is granted.
    task automatic run_burst(input string tag);
        int            g;
        int unsigned   len;
        logic [AW-1:0] a_exp;
        logic [AW-1:0] a_act;
        logic [AW:0]   s_exp;
        logic          req_act;
        g   = exp_grant();
        len = 32'(burst_len);
        @(negedge clk);
        checks++;
        if (sdram_wr_req !== (g == 1) || sdram_rd_req !== (g == 2)) begin
            errors++;
            $display("FAIL %s grant: wr_req=%0b rd_req=%0b required grant code %0d (1=wr 2=rd)",
                     tag, sdram_wr_req, sdram_rd_req, g);
        end
        checks++;
        if (wr_burst_done !== 1'b0 || rd_burst_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: wr_done=%0b rd_done=%0b required 0 0",
                     tag, wr_burst_done, rd_burst_done);
        end
        if (g == 0) return;
        a_exp = (g == 1) ? AW'(m_wr_addr) : AW'(m_rd_addr);
        a_act = (g == 1) ? sdram_wr_addr : sdram_rd_addr;
        checks++;
        if (a_act !== a_exp) begin
            errors++;
            $display("FAIL %s start_addr: got %0d required %0d", tag, a_act, a_exp);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        for (int i = 0; i < int'(len); i++) begin
            if (g == 1) sdram_wr_ack = 1'b1;
            else        sdram_rd_ack = 1'b1;
            @(negedge clk);
        end
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        req_act = (g == 1) ? sdram_wr_req : sdram_rd_req;
        a_act   = (g == 1) ? sdram_wr_addr : sdram_rd_addr;
        checks++;
        if (req_act !== 1'b1 || a_act !== a_exp) begin
            errors++;
            $display("FAIL %s req_hold: req=%0b addr=%0d required req=1 addr=%0d",
                     tag, req_act, a_act, a_exp);
        end
        @(negedge clk);
        if (g == 1) begin
            m_stored    = m_stored + len;
            m_wr_addr   = next_start(m_wr_addr, len);
            m_last_read = 1'b0;
        end else begin
            m_stored    = m_stored - len;
            m_rd_addr   = next_start(m_rd_addr, len);
            m_last_read = 1'b1;
        end
        checks++;
        if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0 ||
            wr_burst_done !== (g == 1) || rd_burst_done !== (g == 2)) begin
            errors++;
            $display("FAIL %s end: wr_req=%0b rd_req=%0b wr_done=%0b rd_done=%0b required req 0 0, done code %0d",
                     tag, sdram_wr_req, sdram_rd_req, wr_burst_done, rd_burst_done, g);
        end
        a_exp = (g == 1) ? AW'(m_wr_addr) : AW'(m_rd_addr);
        a_act = (g == 1) ? sdram_wr_addr : sdram_rd_addr;
        checks++;
        if (a_act !== a_exp) begin
            errors++;
            $display("FAIL %s next_addr: got %0d required %0d", tag, a_act, a_exp);
        end
        s_exp = (AW+1)'(m_stored);
        checks++;
        if (stored_cnt !== s_exp) begin
            errors++;
            $display("FAIL %s stored_cnt: got %0d required %0d", tag, stored_cnt, s_exp);
        end
    endtask

    task automatic test_reset();
        init_end = 1'b0; burst_len = 10'd10; wr_fifo_num = 10'd0; rd_fifo_num = 10'd0;
        rd_valid = 1'b0; sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0 ||
            wr_burst_done !== 1'b0 || rd_burst_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: wr_req=%0b rd_req=%0b wr_done=%0b rd_done=%0b required all 0",
                     sdram_wr_req, sdram_rd_req, wr_burst_done, rd_burst_done);
        end
        checks++;
        if (sdram_wr_addr !== AW'(A_MIN) || sdram_rd_addr !== AW'(A_MIN) || stored_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: wr_addr=%0d rd_addr=%0d stored=%0d required %0d %0d 0",
                     sdram_wr_addr, sdram_rd_addr, stored_cnt, A_MIN, A_MIN);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_init_gate();
        wr_fifo_num = 10'd10;
        burst_len   = 10'd10;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) begin
                errors++;
                $display("FAIL init_hold cycle %0d: wr_req=%0b rd_req=%0b required 0 0",
                         i, sdram_wr_req, sdram_rd_req);
            end
        end
        init_end = 1'b1;
        @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL init_latency: wr_req=%0b one cycle after init_end, required 0", sdram_wr_req);
        end
        run_burst("init_first_write");
    endtask

    task automatic test_basic_write();
        checks++;
        if (sdram_wr_addr !== AW'(10) || stored_cnt !== (AW+1)'(10)) begin
            errors++;
            $display("FAIL basic_write: wr_addr=%0d stored=%0d required 10 10", sdram_wr_addr, stored_cnt);
        end
    endtask

    task automatic test_round_robin();
        rd_valid = 1'b0; wr_fifo_num = 10'd10; rd_fifo_num = 10'd0;
        run_burst("rr_fill");
        rd_valid = 1'b1;
        for (int i = 0; i < 4; i++) run_burst($sformatf("rr_alt%0d", i));
        checks++;
        if (stored_cnt !== (AW+1)'(20) || sdram_rd_addr !== AW'(20)) begin
            errors++;
            $display("FAIL rr_final: stored=%0d rd_addr=%0d required 20 20", stored_cnt, sdram_rd_addr);
        end
    endtask

    task automatic test_wrap_full();
        do_reset();
        rd_valid = 1'b0; wr_fifo_num = 10'd10; rd_fifo_num = 10'd0; burst_len = 10'd10;
        @(negedge clk);
        for (int i = 0; i < 3; i++) run_burst($sformatf("wrap_w%0d", i));
        checks++;
        if (sdram_wr_addr !== AW'(A_MIN) || stored_cnt !== (AW+1)'(30)) begin
            errors++;
            $display("FAIL wrap: wr_addr=%0d stored=%0d required %0d 30", sdram_wr_addr, stored_cnt, A_MIN);
        end
        run_burst("full_blocks_write");
        run_burst("full_blocks_write2");
        rd_valid = 1'b1; rd_fifo_num = 10'd5;
        run_burst("rd_fifo_busy");
        rd_fifo_num = 10'd0;
        run_burst("read_after_full");
        run_burst("write_after_read");
    endtask

    task automatic test_ack_ignored();
        rd_valid = 1'b0; wr_fifo_num = 10'd0; burst_len = 10'd4;
        sdram_wr_ack = 1'b1; sdram_rd_ack = 1'b1;
        repeat (3) @(negedge clk);
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wr_burst_done !== 1'b0 || rd_burst_done !== 1'b0 ||
                sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) begin
                errors++;
                $display("FAIL stray_ack: wr_done=%0b rd_done=%0b wr_req=%0b rd_req=%0b required all 0",
                         wr_burst_done, rd_burst_done, sdram_wr_req, sdram_rd_req);
            end
        end
        wr_fifo_num = 10'd4;
        run_burst("after_stray_ack");
    endtask

    task automatic test_init_drop();
        init_end = 1'b0; wr_fifo_num = 10'd10; burst_len = 10'd2;
        @(negedge clk);
        init_end = 1'b1;
        @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL init_drop: wr_req=%0b rd_req=%0b required 0 0 while re-entering idle",
                     sdram_wr_req, sdram_rd_req);
        end
        run_burst("after_init_drop");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            burst_len   = 10'($urandom_range(0, 12));
            wr_fifo_num = 10'($urandom_range(0, 15));
            rd_fifo_num = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1, 8)) : 10'd0;
            rd_valid    = 1'($urandom_range(0, 1));
            run_burst($sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid_burst();
        rd_valid = 1'b0; wr_fifo_num = 10'd10; burst_len = 10'd10; rd_fifo_num = 10'd0;
        if (m_stored + 10 > CAP) begin
            rd_valid = 1'b1; wr_fifo_num = 10'd0;
            while (m_stored >= 10) run_burst("drain");
            rd_valid = 1'b0; wr_fifo_num = 10'd10;
        end
        run_burst("pre_reset_write");
        @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst_req: wr_req=%0b required 1", sdram_wr_req);
        end
        sdram_wr_ack = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (sdram_wr_req !== 1'b0 || sdram_wr_addr !== AW'(A_MIN) ||
            sdram_rd_addr !== AW'(A_MIN) || stored_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid_burst: wr_req=%0b wr_addr=%0d rd_addr=%0d stored=%0d required 0 %0d %0d 0",
                     sdram_wr_req, sdram_wr_addr, sdram_rd_addr, stored_cnt, A_MIN, A_MIN);
        end
        sdram_wr_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_to_init: wr_req=%0b one cycle after reset release, required 0", sdram_wr_req);
        end
        run_burst("post_reset_write");
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_basic_write();
        test_round_robin();
        test_wrap_full();
        test_ack_ignored();
        test_init_drop();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
